// File: rtl/seg7_glyph_pkg.sv
// Shared constants for the 7-segment message decoder: common-anode segment
// patterns, glyph codes, the expected HELLOASIC sequence and the decode table.
package seg7_glyph_pkg;

    // Common-anode patterns on bits 6:0 (G..A); a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_H     = 7'h09;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_O     = 7'h40;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_S     = 7'h12;
    localparam logic [6:0] SEG_I     = 7'h4F;
    localparam logic [6:0] SEG_C     = 7'h46;

    typedef enum logic [3:0] {
        GLYPH_BLANK   = 4'h0,
        GLYPH_H       = 4'h1,
        GLYPH_E       = 4'h2,
        GLYPH_L       = 4'h3,
        GLYPH_O       = 4'h4,
        GLYPH_A       = 4'h5,
        GLYPH_S       = 4'h6,
        GLYPH_I       = 4'h7,
        GLYPH_C       = 4'h8,
        GLYPH_UNKNOWN = 4'hF
    } glyph_code_e;

    localparam int MSG_LEN = 9;

    localparam logic [3:0] IDX_SEEK = 4'd0;
    localparam logic [3:0] IDX_RESYNC = 4'd1;
    localparam logic [3:0] IDX_LAST = 4'd8;

    localparam glyph_code_e EXPECT_MSG [0:MSG_LEN-1] = '{
        GLYPH_H, GLYPH_E, GLYPH_L, GLYPH_L, GLYPH_O,
        GLYPH_A, GLYPH_S, GLYPH_I, GLYPH_C
    };

    function automatic glyph_code_e decode_glyph(input logic [6:0] seg);
        glyph_code_e code;
        unique case (seg)
            SEG_BLANK: code = GLYPH_BLANK;
            SEG_H:     code = GLYPH_H;
            SEG_E:     code = GLYPH_E;
            SEG_L:     code = GLYPH_L;
            SEG_O:     code = GLYPH_O;
            SEG_A:     code = GLYPH_A;
            SEG_S:     code = GLYPH_S;
            SEG_I:     code = GLYPH_I;
            SEG_C:     code = GLYPH_C;
            default:   code = GLYPH_UNKNOWN;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Debounce for the segment bus: a pattern must repeat STABLE_CYCLES times in a
// row and differ from the last accepted pattern before it is passed on.
module seg7_stable_filter
    import seg7_glyph_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] i_seg,
    output logic       o_accept,
    output logic [6:0] o_pattern
);

    localparam logic [7:0] CNT_TARGET = 8'(STABLE_CYCLES);

    logic [6:0] r_s_q;
    logic [6:0] r_acc_q;
    logic [7:0] r_cnt;
    logic       w_same;
    logic       w_reach;

    assign w_same    = (i_seg == r_s_q);
    // Counter is about to step onto the target on this edge.
    assign w_reach   = w_same && (r_cnt == CNT_TARGET - 8'd1);
    assign o_accept  = w_reach && (r_s_q != r_acc_q);
    assign o_pattern = r_s_q;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_q   <= SEG_BLANK;
            r_acc_q <= SEG_BLANK;
            r_cnt   <= 8'd0;
        end else begin
            r_s_q <= i_seg;
            if (!w_same) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != CNT_TARGET) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (o_accept) begin
                r_acc_q <= r_s_q;
            end
        end
    end

endmodule

// File: rtl/seg7_msg_decoder.sv
// Decodes filtered segment patterns to glyph codes and follows the
// HELLOASIC sequence, pulsing on completion and on ordering errors.
module seg7_msg_decoder
    import seg7_glyph_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seg_in,
    output logic [3:0] glyph,
    output logic       glyph_valid,
    output logic       glyph_unknown,
    output logic       msg_done,
    output logic       msg_error,
    output logic [3:0] err_count
);

    logic        w_accept;
    logic [6:0]  w_pattern;
    glyph_code_e w_code;
    logic        w_take;
    logic        w_match;
    logic        w_unused_dp;
    logic [3:0]  w_idx_next;
    logic        w_done_next;
    logic        w_error_next;

    logic [3:0]  r_idx;
    logic [3:0]  r_glyph;
    logic        r_glyph_valid;
    logic        r_glyph_unknown;
    logic        r_msg_done;
    logic        r_msg_error;
    logic [3:0]  r_err_count;

    // The decimal point carries no glyph information.
    assign w_unused_dp = seg_in[7];

    seg7_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk       (clk),
        .reset     (reset),
        .i_seg     (seg_in[6:0]),
        .o_accept  (w_accept),
        .o_pattern (w_pattern)
    );

    assign w_code  = decode_glyph(w_pattern);
    assign w_take  = w_accept && (w_code != GLYPH_BLANK);
    assign w_match = (w_code == EXPECT_MSG[r_idx]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= IDX_SEEK;
        end else begin
            r_idx <= w_idx_next;
        end
    end

    // NOTE: default assignment first so no path through always_comb leaves a latch.
    always_comb begin
        w_idx_next = r_idx;
        if (w_take) begin
            if (w_match) begin
                w_idx_next = (r_idx == IDX_LAST) ? IDX_SEEK : r_idx + 4'd1;
            end else begin
                // An unexpected H can only start a new message.
                w_idx_next = (w_code == GLYPH_H) ? IDX_RESYNC : IDX_SEEK;
            end
        end
    end

    always_comb begin
        w_done_next  = w_take && w_match && (r_idx == IDX_LAST);
        w_error_next = w_take && !w_match;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_glyph         <= 4'h0;
            r_glyph_valid   <= 1'b0;
            r_glyph_unknown <= 1'b0;
            r_msg_done      <= 1'b0;
            r_msg_error     <= 1'b0;
            r_err_count     <= 4'd0;
        end else begin
            r_glyph_valid   <= w_take;
            r_glyph_unknown <= w_take && (w_code == GLYPH_UNKNOWN);
            r_msg_done      <= w_done_next;
            r_msg_error     <= w_error_next;
            if (w_take) begin
                r_glyph <= w_code;
            end
            if (w_error_next && (r_err_count != 4'hF)) begin
                r_err_count <= r_err_count + 4'd1;
            end
        end
    end

    assign glyph         = r_glyph;
    assign glyph_valid   = r_glyph_valid;
    assign glyph_unknown = r_glyph_unknown;
    assign msg_done      = r_msg_done;
    assign msg_error     = r_msg_error;
    assign err_count     = r_err_count;

endmodule

// File: tb/tb_seg7_msg_decoder.sv
// Directed bench for seg7_msg_decoder with STABLE_CYCLES = 4: latency,
// glitch filtering, message tracking, error counting and reset behaviour.
module tb_seg7_msg_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] seg_in;
    logic [3:0] glyph;
    logic       glyph_valid;
    logic       glyph_unknown;
    logic       msg_done;
    logic       msg_error;
    logic [3:0] err_count;

    int checks = 0;
    int errors = 0;

    int mon_valid = 0;
    int mon_done = 0;
    int mon_err = 0;
    int mon_both = 0;
    int mon_orphan = 0;

    localparam logic [7:0] P_BLANK = 8'hFF;
    localparam logic [7:0] P_H = 8'h89;
    localparam logic [7:0] P_E = 8'h86;
    localparam logic [7:0] P_L = 8'hC7;
    localparam logic [7:0] P_O = 8'hC0;
    localparam logic [7:0] P_C = 8'hC6;
    localparam logic [7:0] P_UNK = 8'h00;
    localparam logic [7:0] MSG_PAT [0:8] = '{8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0,
                                             8'h88, 8'h92, 8'hCF, 8'hC6};

    always #5 clk = ~clk;

    seg7_msg_decoder #(
        .STABLE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .seg_in        (seg_in),
        .glyph         (glyph),
        .glyph_valid   (glyph_valid),
        .glyph_unknown (glyph_unknown),
        .msg_done      (msg_done),
        .msg_error     (msg_error),
        .err_count     (err_count)
    );

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (glyph_valid) mon_valid <= mon_valid + 1;
        if (msg_done) mon_done <= mon_done + 1;
        if (msg_error) mon_err <= mon_err + 1;
        if (msg_done && msg_error) mon_both <= mon_both + 1;
        if (glyph_unknown && !glyph_valid) mon_orphan <= mon_orphan + 1;
    end

    task automatic hold(input logic [7:0] p, input int n);
        seg_in = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] p);
        hold(p, 6);
        hold(P_BLANK, 6);
    endtask

    task automatic send_full_msg();
        for (int i = 0; i < 9; i++) begin
            send(MSG_PAT[i]);
            if (i == 4) hold(P_BLANK, 6);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        seg_in = P_BLANK;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        seg_in = P_BLANK;
        repeat (3) @(negedge clk);
        checks++;
        if ({glyph, err_count} !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: got glyph/err_count %h, expected 00", {glyph, err_count});
        end
        checks++;
        if ({glyph_valid, glyph_unknown, msg_done, msg_error} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: got %b, expected 0000",
                     {glyph_valid, glyph_unknown, msg_done, msg_error});
        end
        reset = 1'b0;
    endtask

    task automatic test_latency();
        int n_valid = 0;
        int first = 0;
        logic [3:0] g = 4'h0;
        do_reset();
        seg_in = P_H;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (glyph_valid) begin
                n_valid++;
                if (first == 0) first = i;
                g = glyph;
            end
        end
        checks++;
        if (n_valid != 1) begin
            errors++;
            $display("FAIL latency_count: got %0d pulses, expected 1", n_valid);
        end
        checks++;
        if (first != 5) begin
            errors++;
            $display("FAIL latency_cycle: got cycle %0d, expected 5", first);
        end
        checks++;
        if (g !== 4'h1) begin
            errors++;
            $display("FAIL latency_glyph: got %h, expected 1", g);
        end
        hold(P_BLANK, 6);
    endtask

    task automatic test_glitch();
        int n_valid = 0;
        int first = 0;
        logic [3:0] g = 4'h0;
        do_reset();
        hold(P_H, 2);
        seg_in = P_E;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (glyph_valid) begin
                n_valid++;
                if (first == 0) first = i;
                g = glyph;
            end
        end
        checks++;
        if (n_valid != 1 || first != 5 || g !== 4'h2) begin
            errors++;
            $display("FAIL glitch_filter: got %0d pulses at %0d glyph %h, expected 1 at 5 glyph 2",
                     n_valid, first, g);
        end
        checks++;
        if (err_count !== 4'd1) begin
            errors++;
            $display("FAIL glitch_seek_err: got %0d, expected 1", err_count);
        end
        hold(P_BLANK, 6);
        // Only the decimal point toggles; the count must keep running.
        n_valid = 0;
        first = 0;
        seg_in = 8'h86;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (glyph_valid) begin
                n_valid++;
                if (first == 0) first = i;
                g = glyph;
            end
            seg_in = (i % 2 == 1) ? 8'h06 : 8'h86;
        end
        checks++;
        if (n_valid != 1 || first != 5 || g !== 4'h2) begin
            errors++;
            $display("FAIL dp_ignored: got %0d pulses at %0d glyph %h, expected 1 at 5 glyph 2",
                     n_valid, first, g);
        end
        hold(P_BLANK, 6);
    endtask

    task automatic test_full_message();
        int s_valid, s_done, s_err;
        do_reset();
        #1;
        s_valid = mon_valid; s_done = mon_done; s_err = mon_err;
        send_full_msg();
        #1;
        checks++;
        if (mon_valid - s_valid != 9) begin
            errors++;
            $display("FAIL full_valid: got %0d, expected 9", mon_valid - s_valid);
        end
        checks++;
        if (mon_done - s_done != 1 || mon_err - s_err != 0) begin
            errors++;
            $display("FAIL full_done_err: got done %0d err %0d, expected 1 0",
                     mon_done - s_done, mon_err - s_err);
        end
        checks++;
        if (err_count !== 4'd0 || glyph !== 4'h8) begin
            errors++;
            $display("FAIL full_state: got err_count %0d glyph %h, expected 0 8", err_count, glyph);
        end
    endtask

    task automatic test_out_of_order();
        int s_done, s_err;
        do_reset();
        #1;
        s_done = mon_done; s_err = mon_err;
        send(P_H); send(P_E); send(P_L); send(P_O);
        #1;
        checks++;
        if (mon_err - s_err != 1 || err_count !== 4'd1) begin
            errors++;
            $display("FAIL order_err: got %0d pulses err_count %0d, expected 1 1",
                     mon_err - s_err, err_count);
        end
        send_full_msg();
        #1;
        checks++;
        if (mon_done - s_done != 1 || mon_err - s_err != 1 || err_count !== 4'd1) begin
            errors++;
            $display("FAIL order_recover: got done %0d err %0d err_count %0d, expected 1 1 1",
                     mon_done - s_done, mon_err - s_err, err_count);
        end
    endtask

    task automatic test_unknown();
        int s_err;
        logic seen = 1'b0;
        do_reset();
        #1;
        s_err = mon_err;
        seg_in = P_UNK;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (glyph_valid && glyph_unknown && msg_error && glyph === 4'hF) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL unknown_pulse: got %b, expected 1", seen);
        end
        hold(P_BLANK, 6);
        for (int n = 1; n <= 16; n++) begin
            send(P_UNK);
            if (n == 13) begin
                checks++;
                if (err_count !== 4'd14) begin
                    errors++;
                    $display("FAIL err_count_14: got %0d, expected 14", err_count);
                end
            end
        end
        #1;
        checks++;
        if (err_count !== 4'd15 || mon_err - s_err != 17) begin
            errors++;
            $display("FAIL err_saturate: got %0d after %0d errors, expected 15 after 17",
                     err_count, mon_err - s_err);
        end
    endtask

    task automatic test_reset_mid();
        int s_err;
        do_reset();
        send(P_E);
        send(P_H); send(P_E); send(P_L);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({glyph, err_count, glyph_valid, glyph_unknown, msg_done, msg_error} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid: got %h, expected 000",
                     {glyph, err_count, glyph_valid, glyph_unknown, msg_done, msg_error});
        end
        reset = 1'b0;
        #1;
        s_err = mon_err;
        send(P_E);
        #1;
        checks++;
        if (mon_err - s_err != 1 || err_count !== 4'd1 || glyph !== 4'h2) begin
            errors++;
            $display("FAIL reset_mid_after: got err %0d err_count %0d glyph %h, expected 1 1 2",
                     mon_err - s_err, err_count, glyph);
        end
    endtask

    task automatic test_back_to_back();
        int s_valid, s_err;
        do_reset();
        #1;
        s_valid = mon_valid; s_err = mon_err;
        hold(P_H, 6);
        hold(P_E, 20);
        hold(P_BLANK, 6);
        #1;
        checks++;
        if (mon_valid - s_valid != 2 || mon_err - s_err != 0) begin
            errors++;
            $display("FAIL back_to_back: got valid %0d err %0d, expected 2 0",
                     mon_valid - s_valid, mon_err - s_err);
        end
        checks++;
        if (mon_both != 0 || mon_orphan != 0) begin
            errors++;
            $display("FAIL pulse_rules: got both %0d orphan %0d, expected 0 0", mon_both, mon_orphan);
        end
    endtask

    initial begin
        reset  = 1'b1;
        seg_in = P_BLANK;
        test_reset();
        test_latency();
        test_glitch();
        test_full_message();
        test_out_of_order();
        test_unknown();
        test_reset_mid();
        test_back_to_back();
        if (P_C == 8'h00) $display("unreachable");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_msg_decoder.md
Name: seg7_msg_decoder

Overview:
- Receive-side counterpart of the 7-segment message generator.
- Samples an 8-bit common-anode segment bus, filters out transient patterns, and decodes each stable glyph to a 4-bit code.
- Tracks the expected letter sequence H E L L O A S I C and flags completion and ordering errors.
- Sits on the bench/loopback side of the display bus; used for self-checking and for silicon bring-up.

Parameters:
- STABLE_CYCLES, 4: consecutive equal samples a pattern must hold before it is accepted. Legal range 1..255; 0 is illegal.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- seg_in  in  8  common-anode pattern: bit7 = dp, bits6:0 = G..A, 0 = segment lit
- glyph  out  4  last accepted non-blank glyph code
- glyph_valid  out  1  one-cycle pulse on acceptance of a non-blank glyph
- glyph_unknown  out  1  pulses together with glyph_valid when the pattern is not in the table
- msg_done  out  1  one-cycle pulse when a complete message has been decoded in order
- msg_error  out  1  one-cycle pulse on an out-of-order or unknown glyph
- err_count  out  4  saturating error count

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset state:
  - s_q = 7'h7F; acc_q = 7'h7F (blank); cnt = 0; idx = 0.
  - glyph = 0; err_count = 0; all pulse outputs = 0.
- Reset mid-message abandons the partial message and clears err_count.
- Decode uses bits6:0 only; dp is ignored everywhere, including the stability compare.
- Glyph table (bits6:0 -> code):
  - 7F blank -> 0 (internal only, never output)
  - 09 H -> 1; 06 E -> 2; 47 L -> 3; 40 O -> 4
  - 08 A -> 5; 12 S -> 6; 4F I -> 7; 46 C -> 8
  - any other pattern -> F, unknown
- Stability filter, evaluated at every edge:
  - If seg_in[6:0] != s_q: cnt <= 0.
  - Else if cnt != STABLE_CYCLES: cnt <= cnt + 1.
  - s_q <= seg_in[6:0] unconditionally.
  - Acceptance happens at the edge where cnt becomes STABLE_CYCLES, provided s_q != acc_q. At that edge acc_q <= s_q.
- Latency: a value first sampled at edge k is accepted at edge k+STABLE_CYCLES. The resulting outputs are registered and visible in the cycle after that edge.
- A pattern held indefinitely is accepted once only.
- The same letter twice in a row is only seen if a blank is accepted between the two.
- If seg_in changes on the edge where cnt would reach STABLE_CYCLES, cnt clears and nothing is accepted.
- Blank acceptance: updates acc_q only. No pulse, no FSM effect; any number of consecutive blanks is allowed.
- Non-blank acceptance:
  - glyph <= code; glyph_valid = 1.
  - glyph_unknown = 1 when code is F.
- Message FSM, state idx 0..8 indexing the expected sequence H E L L O A S I C. SEEK is idx = 0; TRACK is idx 1..8.
  - Accepted code == EXPECT[idx] and idx < 8: idx <= idx + 1.
  - Accepted code == EXPECT[8] with idx = 8: msg_done = 1 and idx <= 0.
  - Mismatch, including unknown: msg_error = 1; err_count increments, saturating at 15; idx <= 1 if code is H (resync), else idx <= 0.
- msg_done and msg_error are never asserted in the same cycle.
- Pulses are asserted in the same cycle as the glyph_valid they relate to.

Decomposition:
- Package seg7_glyph_pkg holds:
  - the segment pattern constants (common anode);
  - glyph code constants, including BLANK = 0 and UNKNOWN = F;
  - the 9-entry expected-message constant array.
- Sub-module seg7_stable_filter holds s_q, cnt and acc_q and emits accept_pulse plus the accepted pattern.
- Decode and FSM stay in the top module.

Test Plan:
- Reset, then 0x89 held 10 cycles with STABLE_CYCLES=4: exactly one glyph_valid pulse with glyph=1, on the cycle after edge k+4.
- Glitch filter: 0x89 for 2 cycles then 0x86 held: no H accepted; E accepted at k'+4. Toggling only bit7 (0x86/0x06) does not restart the count.
- Full message, one blank between letters and two blanks between O and A, each pattern held 6 cycles: 9 glyph_valid pulses, msg_done once on C, msg_error never, err_count=0.
- H E L O: msg_error on O, err_count=1, idx back to 0. Following H E L L O A S I C: msg_done once.
- Unknown pattern 0x00 gives glyph_valid, glyph_unknown, glyph=F and msg_error. After 17 errors err_count=15.
- Send H E L, assert reset 1 cycle, then send E: all outputs 0 after reset, then msg_error with err_count=1.
